lut_dds_multichannel: RTL and testbench

- Next-generation waveform generator: one shared, run-time-writable waveform LUT read by NUM_CH independent channels.
- Each channel has a phase accumulator, programmable phase increment and phase offset, and continuous or N-period burst mode.
- Sits between the control middleware (LUT/config writes, start/stop) and the DAC/stimulation datapath.
- Replaces fixed-table, fixed-rate LUT counters where several channels with individual frequency and phase are needed.

---
 rtl/lut_dds_multichannel.sv | 154 +++++++++++++++
 tb/tb_lut_dds_multichannel.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_dds_multichannel.sv
// Multichannel LUT-based DDS waveform generator.
//
// One shared, run-time-writable waveform LUT is read by NUM_CH independent
// channels. Each channel owns a phase accumulator with programmable phase
// increment and phase offset, and runs either continuously or for a
// programmed number of accumulator periods (burst).
//
// Ports:
//   CLK_SYS      system clock, rising edge
//   RST          asynchronous active-high reset
//   EN           global enable; low freezes all channels and masks strobes
//   LUT_WR_*     synchronous LUT write port (address, signed sample)
//   CFG_WR_EN    load PINC/POFF/BURST of channel CFG_CH (out of range: ignored)
//   START/STOP   per-channel start/stop pulses (STOP dominates)
//   LUT_VALUE    per-channel sample, channel c at [c*BIT_WIDTH +: BIT_WIDTH]
//   LUT_VALID    per-channel sample-valid strobe
//   LUT_END      per-channel one-cycle pulse after an accumulator wrap
//   BUSY         per-channel RUN indicator
module lut_dds_multichannel #(
  parameter int NUM_CH      = 2,
  parameter int BIT_WIDTH   = 12,
  parameter int LUT_DEPTH   = 256,
  parameter int PHASE_WIDTH = 24,
  parameter int BURST_WIDTH = 16,
  localparam int ADDR_W     = $clog2(LUT_DEPTH),
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          CLK_SYS,
  input  logic                          RST,
  input  logic                          EN,
  input  logic                          LUT_WR_EN,
  input  logic [ADDR_W-1:0]             LUT_WR_ADDR,
  input  logic signed [BIT_WIDTH-1:0]   LUT_WR_DATA,
  input  logic                          CFG_WR_EN,
  input  logic [CH_W-1:0]               CFG_CH,
  input  logic [PHASE_WIDTH-1:0]        CFG_PINC,
  input  logic [PHASE_WIDTH-1:0]        CFG_POFF,
  input  logic [BURST_WIDTH-1:0]        CFG_BURST,
  input  logic [NUM_CH-1:0]             START,
  input  logic [NUM_CH-1:0]             STOP,
  output logic [NUM_CH*BIT_WIDTH-1:0]   LUT_VALUE,
  output logic [NUM_CH-1:0]             LUT_VALID,
  output logic [NUM_CH-1:0]             LUT_END,
  output logic [NUM_CH-1:0]             BUSY
);

  localparam int SHIFT = PHASE_WIDTH - ADDR_W;

  typedef enum logic {IDLE, RUN} state_t;

  // Shared waveform table; deliberately not reset.
  logic [BIT_WIDTH-1:0] lut [LUT_DEPTH];

  always_ff @(posedge CLK_SYS) begin
    if (LUT_WR_EN) lut[LUT_WR_ADDR] <= LUT_WR_DATA;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] pinc_q, poff_q;
    logic [BURST_WIDTH-1:0] burst_cfg_q;
    logic [BURST_WIDTH-1:0] burst_left_q, burst_left_d;
    logic [PHASE_WIDTH:0]   sum;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   wrap;
    logic                   cfg_hit;
    logic [ADDR_W-1:0]      addr_q;
    logic                   run_d1_q;
    logic                   valid_q;
    logic                   end_q;
    logic [BIT_WIDTH-1:0]   value_q;

    assign cfg_hit = CFG_WR_EN && (int'(CFG_CH) == c);
    assign sum     = {1'b0, acc_q} + {1'b0, pinc_q};
    assign phase   = acc_q + poff_q;

    always_ff @(posedge CLK_SYS or posedge RST) begin
      if (RST) begin
        pinc_q      <= '0;
        poff_q      <= '0;
        burst_cfg_q <= '0;
      end else if (cfg_hit) begin
        pinc_q      <= CFG_PINC;
        poff_q      <= CFG_POFF;
        burst_cfg_q <= CFG_BURST;
      end
    end

    // burst_left == 0 means continuous; it is only loaded on START, so a
    // burst reconfiguration during RUN does not disturb the running burst.
    always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      burst_left_d = burst_left_q;
      wrap         = 1'b0;
      if (STOP[c]) begin
        state_d = IDLE;
        acc_d   = '0;
      end else if (START[c]) begin
        state_d      = RUN;
        acc_d        = '0;
        burst_left_d = burst_cfg_q;
      end else if (state_q == RUN && EN) begin
        acc_d = sum[PHASE_WIDTH-1:0];
        wrap  = sum[PHASE_WIDTH];
        if (wrap && burst_left_q != '0) begin
          if (burst_left_q == BURST_WIDTH'(1)) begin
            state_d      = IDLE;
            acc_d        = '0;
            burst_left_d = '0;
          end else begin
            burst_left_d = burst_left_q - BURST_WIDTH'(1);
          end
        end
      end
    end

    // Read pipeline: accumulator -> address register -> sample register.
    // Stages only advance with EN; address/sample registers only load while
    // fed from RUN, so the last sample is held once the channel stops.
    always_ff @(posedge CLK_SYS or posedge RST) begin
      if (RST) begin
        state_q      <= IDLE;
        acc_q        <= '0;
        burst_left_q <= '0;
        addr_q       <= '0;
        run_d1_q     <= 1'b0;
        valid_q      <= 1'b0;
        end_q        <= 1'b0;
        value_q      <= '0;
      end else begin
        state_q      <= state_d;
        acc_q        <= acc_d;
        burst_left_q <= burst_left_d;
        if (EN) begin
          if (state_q == RUN) addr_q <= ADDR_W'(phase >> SHIFT);
          if (run_d1_q) value_q <= lut[addr_q];
          run_d1_q <= (state_q == RUN);
          valid_q  <= run_d1_q;
          end_q    <= wrap;
        end
      end
    end

    // Strobes are held with the frozen pipeline and masked while EN is low,
    // so each sample and each wrap is reported exactly once.
    assign LUT_VALUE[c*BIT_WIDTH +: BIT_WIDTH] = value_q;
    assign LUT_VALID[c] = valid_q & EN;
    assign LUT_END[c]   = end_q & EN;
    assign BUSY[c]      = (state_q == RUN);
  end

endmodule

// File: tb/tb_lut_dds_multichannel.sv
// Self-checking bench for lut_dds_multichannel (NUM_CH=2, BIT_WIDTH=8,
// LUT_DEPTH=16, PHASE_WIDTH=8, LUT[i] = i*8-64). A second instance with
// three channels exercises an out-of-range configuration channel.
module tb_lut_dds_multichannel;

  logic        CLK_SYS = 1'b0;
  logic        RST;
  logic        EN;
  logic        LUT_WR_EN;
  logic [3:0]  LUT_WR_ADDR;
  logic [7:0]  LUT_WR_DATA;
  logic        CFG_WR_EN;
  logic [0:0]  CFG_CH;
  logic [7:0]  CFG_PINC;
  logic [7:0]  CFG_POFF;
  logic [15:0] CFG_BURST;
  logic [1:0]  START;
  logic [1:0]  STOP;
  logic [15:0] LUT_VALUE;
  logic [1:0]  LUT_VALID;
  logic [1:0]  LUT_END;
  logic [1:0]  BUSY;

  logic        CFG_WR_EN2;
  logic [1:0]  CFG_CH2;
  logic [2:0]  START2;
  logic [2:0]  STOP2;
  logic [23:0] LUT_VALUE2;
  logic [2:0]  LUT_VALID2;
  logic [2:0]  LUT_END2;
  logic [2:0]  BUSY2;

  lut_dds_multichannel #(
    .NUM_CH(2), .BIT_WIDTH(8), .LUT_DEPTH(16), .PHASE_WIDTH(8), .BURST_WIDTH(16)
  ) dut (
    .CLK_SYS(CLK_SYS), .RST(RST), .EN(EN),
    .LUT_WR_EN(LUT_WR_EN), .LUT_WR_ADDR(LUT_WR_ADDR), .LUT_WR_DATA(LUT_WR_DATA),
    .CFG_WR_EN(CFG_WR_EN), .CFG_CH(CFG_CH), .CFG_PINC(CFG_PINC),
    .CFG_POFF(CFG_POFF), .CFG_BURST(CFG_BURST),
    .START(START), .STOP(STOP),
    .LUT_VALUE(LUT_VALUE), .LUT_VALID(LUT_VALID), .LUT_END(LUT_END), .BUSY(BUSY)
  );

  lut_dds_multichannel #(
    .NUM_CH(3), .BIT_WIDTH(8), .LUT_DEPTH(16), .PHASE_WIDTH(8), .BURST_WIDTH(16)
  ) dut3 (
    .CLK_SYS(CLK_SYS), .RST(RST), .EN(EN),
    .LUT_WR_EN(LUT_WR_EN), .LUT_WR_ADDR(LUT_WR_ADDR), .LUT_WR_DATA(LUT_WR_DATA),
    .CFG_WR_EN(CFG_WR_EN2), .CFG_CH(CFG_CH2), .CFG_PINC(CFG_PINC),
    .CFG_POFF(CFG_POFF), .CFG_BURST(CFG_BURST),
    .START(START2), .STOP(STOP2),
    .LUT_VALUE(LUT_VALUE2), .LUT_VALID(LUT_VALID2), .LUT_END(LUT_END2), .BUSY(BUSY2)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int exp_q0[$];
  int exp_q1[$];
  int valid_cnt[2];
  int first_valid[2];
  int end_cnt[2];
  int end_gap[2];
  int last_end[2];

  always @(posedge CLK_SYS) cyc++;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lut_val(input int i);
    return i * 8 - 64;
  endfunction

  // Output monitor: pops the scoreboard on every valid sample.
  always @(negedge CLK_SYS) begin
    if (LUT_VALID[0]) begin
      valid_cnt[0]++;
      if (first_valid[0] < 0) first_valid[0] = cyc;
      if (exp_q0.size() == 0) check("ch0_unexpected_valid", int'(LUT_VALID[0]), 0);
      else check("ch0_sample", int'($signed(LUT_VALUE[7:0])), exp_q0.pop_front());
    end
    if (LUT_VALID[1]) begin
      valid_cnt[1]++;
      if (first_valid[1] < 0) first_valid[1] = cyc;
      if (exp_q1.size() == 0) check("ch1_unexpected_valid", int'(LUT_VALID[1]), 0);
      else check("ch1_sample", int'($signed(LUT_VALUE[15:8])), exp_q1.pop_front());
    end
    for (int c = 0; c < 2; c++) begin
      if (LUT_END[c]) begin
        end_cnt[c]++;
        end_gap[c]  = cyc - last_end[c];
        last_end[c] = cyc;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK_SYS);
      #1;
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < 2; c++) begin
      valid_cnt[c]   = 0;
      first_valid[c] = -1;
      end_cnt[c]     = 0;
      end_gap[c]     = 0;
      last_end[c]    = 0;
    end
  endtask

  task automatic cfg(input int ch, input int pinc, input int poff, input int burst);
    CFG_WR_EN = 1'b1;
    CFG_CH    = 1'(ch);
    CFG_PINC  = 8'(pinc);
    CFG_POFF  = 8'(poff);
    CFG_BURST = 16'(burst);
    tick();
    CFG_WR_EN = 1'b0;
  endtask

  task automatic lut_write(input int addr, input int data);
    LUT_WR_EN   = 1'b1;
    LUT_WR_ADDR = 4'(addr);
    LUT_WR_DATA = 8'(data);
    tick();
    LUT_WR_EN   = 1'b0;
  endtask

  // Expected samples for n accumulator steps: top 4 of 8 phase bits.
  task automatic push_seq(input int ch, input int pinc, input int poff, input int n);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = ((k * pinc + poff) % 256) / 16;
      if (ch == 0) exp_q0.push_back(lut_val(idx));
      else         exp_q1.push_back(lut_val(idx));
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    START = m;
    tick();
    START = 2'b00;
  endtask

  task automatic pulse_stop(input logic [1:0] m);
    STOP = m;
    tick();
    STOP = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int end2_any;
    RST = 1'b1; EN = 1'b0; LUT_WR_EN = 1'b0; LUT_WR_ADDR = '0; LUT_WR_DATA = '0;
    CFG_WR_EN = 1'b0; CFG_CH = '0; CFG_PINC = '0; CFG_POFF = '0; CFG_BURST = '0;
    START = '0; STOP = '0; CFG_WR_EN2 = 1'b0; CFG_CH2 = '0; START2 = '0; STOP2 = '0;
    clear_stats();

    // Reset state, before any clock edge.
    #3;
    check("rst_value", int'(LUT_VALUE), 0);
    check("rst_valid", int'(LUT_VALID), 0);
    check("rst_end",   int'(LUT_END), 0);
    check("rst_busy",  int'(BUSY), 0);
    check("rst_busy3", int'(BUSY2), 0);
    tick(2);
    RST = 1'b0;
    EN  = 1'b1;
    for (int i = 0; i < 16; i++) lut_write(i, lut_val(i));

    // Out-of-range configuration channel on the 3-channel instance.
    CFG_WR_EN2 = 1'b1; CFG_CH2 = 2'd3; CFG_PINC = 8'd16; CFG_POFF = 8'd64; CFG_BURST = 16'd1;
    tick();
    CFG_WR_EN2 = 1'b0;
    START2 = 3'b111;
    tick();
    START2 = 3'b000;
    end2_any = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_SYS);
      end2_any = end2_any | int'(LUT_END2);
      tick();
    end
    @(negedge CLK_SYS);
    check("cfgch3_end",   end2_any, 0);
    check("cfgch3_busy",  int'(BUSY2), 7);
    check("cfgch3_valid", int'(LUT_VALID2), 7);
    for (int c = 0; c < 3; c++)
      check("cfgch3_value", int'($signed(LUT_VALUE2[c*8 +: 8])), lut_val(0));
    tick();
    STOP2 = 3'b111;
    tick();
    STOP2 = 3'b000;

    // Continuous ch0.
    clear_stats();
    cfg(0, 16, 0, 0);
    push_seq(0, 16, 0, 40);
    n = cyc;
    pulse_start(2'b01);
    tick(19);
    check("cont_busy_run", int'(BUSY[0]), 1);
    tick(20);
    pulse_stop(2'b01);
    check("cont_busy_stop", int'(BUSY[0]), 0);
    tick(4);
    check("cont_first_valid", first_valid[0], n + 3);
    check("cont_valid_cnt", valid_cnt[0], 40);
    check("cont_end_cnt", end_cnt[0], 2);
    check("cont_end_gap", end_gap[0], 16);
    check("cont_sb_empty", exp_q0.size(), 0);

    // Burst of 2 periods on ch0.
    clear_stats();
    cfg(0, 16, 0, 2);
    push_seq(0, 16, 0, 32);
    n = cyc;
    pulse_start(2'b01);
    tick(31);
    check("burst_busy_last", int'(BUSY[0]), 1);
    tick();
    check("burst_busy_fall", int'(BUSY[0]), 0);
    tick(5);
    @(negedge CLK_SYS);
    check("burst_valid_cnt", valid_cnt[0], 32);
    check("burst_end_cnt", end_cnt[0], 2);
    check("burst_last_end", last_end[0], n + 33);
    check("burst_hold_value", int'($signed(LUT_VALUE[7:0])), 56);
    check("burst_hold_valid", int'(LUT_VALID[0]), 0);
    check("burst_sb_empty", exp_q0.size(), 0);
    tick();

    // Two concurrent channels.
    clear_stats();
    cfg(0, 16, 0, 0);
    cfg(1, 8, 128, 0);
    push_seq(0, 16, 0, 72);
    push_seq(1, 8, 128, 72);
    n = cyc;
    pulse_start(2'b11);
    tick(71);
    pulse_stop(2'b11);
    tick(4);
    check("dual_first_valid1", first_valid[1], n + 3);
    check("dual_end_cnt0", end_cnt[0], 4);
    check("dual_end_gap0", end_gap[0], 16);
    check("dual_end_cnt1", end_cnt[1], 2);
    check("dual_end_gap1", end_gap[1], 32);
    check("dual_sb_empty0", exp_q0.size(), 0);
    check("dual_sb_empty1", exp_q1.size(), 0);

    // Restart mid-run, then START together with STOP.
    clear_stats();
    push_seq(0, 16, 0, 10);
    push_seq(0, 16, 0, 10);
    pulse_start(2'b01);
    tick(9);
    pulse_start(2'b01);
    tick(9);
    START = 2'b01; STOP = 2'b01;
    tick();
    START = 2'b00; STOP = 2'b00;
    check("startstop_busy", int'(BUSY[0]), 0);
    tick(5);
    check("startstop_busy_later", int'(BUSY[0]), 0);
    check("restart_valid_cnt", valid_cnt[0], 20);
    check("restart_sb_empty", exp_q0.size(), 0);

    // Asynchronous reset mid-run.
    clear_stats();
    push_seq(0, 16, 0, 50);
    pulse_start(2'b01);
    tick(8);
    #2;
    RST = 1'b1;
    #1;
    check("arst_value", int'(LUT_VALUE), 0);
    check("arst_valid", int'(LUT_VALID), 0);
    check("arst_end",   int'(LUT_END), 0);
    check("arst_busy",  int'(BUSY), 0);
    exp_q0.delete();
    exp_q1.delete();
    tick();
    RST = 1'b0;
    tick();

    // EN low for 5 cycles mid-run.
    clear_stats();
    cfg(0, 16, 0, 0);
    push_seq(0, 16, 0, 25);
    pulse_start(2'b01);
    tick(9);
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_SYS);
      check("enlow_valid", int'(LUT_VALID[0]), 0);
      check("enlow_value", int'($signed(LUT_VALUE[7:0])), lut_val(7));
      tick();
    end
    EN = 1'b1;
    tick(15);
    pulse_stop(2'b01);
    tick(4);
    check("enlow_valid_cnt", valid_cnt[0], 25);
    check("enlow_sb_empty", exp_q0.size(), 0);

    // LUT write to the address currently in the read register.
    clear_stats();
    for (int k = 0; k < 32; k++) exp_q0.push_back((k == 21) ? 100 : lut_val(k % 16));
    pulse_start(2'b01);
    tick(6);
    lut_write(5, 100);
    tick(24);
    pulse_stop(2'b01);
    tick(4);
    check("lutwr_valid_cnt", valid_cnt[0], 32);
    check("lutwr_sb_empty", exp_q0.size(), 0);
    lut_write(5, lut_val(5));

    // PINC change during RUN.
    clear_stats();
    push_seq(0, 16, 0, 10);
    for (int j = 0; j < 10; j++) exp_q0.push_back(lut_val(((160 + 32 * j) % 256) / 16));
    pulse_start(2'b01);
    tick(9);
    cfg(0, 32, 0, 0);
    tick(9);
    pulse_stop(2'b01);
    tick(4);
    check("pinc_valid_cnt", valid_cnt[0], 20);
    check("pinc_sb_empty", exp_q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
